div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter DIV_LATENCY, default 4, meaning divider edges from operand sample to valid quotient/remain.
REQ-002 SHALL have parameter DIV_W, default 16, meaning operand/result width.
REQ-003 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  2  per-requester request valid (bit i = requester i).
REQ-006 SHALL have port req_ready  out  2  per-requester request accepted this cycle.
REQ-007 SHALL have port req_numer  in  2*DIV_W  packed {r1,r0} numerators.
REQ-008 SHALL have port req_denom  in  2*DIV_W  packed {r1,r0} denominators.
REQ-009 SHALL have port res_valid  out  2  per-requester result held.
REQ-010 SHALL have port res_ready  in  2  per-requester result consumed.
REQ-011 SHALL have port res_quotient  out  2*DIV_W  packed results.
REQ-012 SHALL have port res_remain  out  2*DIV_W  packed remainders.
REQ-013 SHALL have port res_dz  out  2  divide-by-zero flag, valid with res_valid.
REQ-014 SHALL have ports div_numer, div_denom  out  DIV_W  registered operands to the shared pipelined divider.
REQ-015 SHALL have ports div_quotient, div_remain  in  DIV_W  divider outputs.

Function
REQ-016 SHALL keep per-requester FSM IDLE -> WAIT (issued to divider) -> DONE (result held) -> IDLE; at most one outstanding op per requester.
REQ-017 SHALL accept (req_ready[i]=1) only a requester in IDLE with req_valid[i]=1 that wins arbitration; at most one accept per cycle.
REQ-018 SHALL arbitrate round-robin: when both eligible, grant the one not granted last; single eligible requester always granted; pointer updates only on accept.
REQ-019 SHALL, on accept with denom!=0, register operands onto div_numer/div_denom in the next cycle and push tag {valid,id} into a DIV_LATENCY+1 deep shift register.
REQ-020 SHALL drive div_numer/div_denom to 0 in cycles with no issue.
REQ-021 SHALL, when the tag emerges valid, capture div_quotient/div_remain into result register of tag id, set res_valid, state DONE; res_valid rises after edge k+DIV_LATENCY+2 for accept at edge k (k+6 for default).
REQ-022 SHALL, on accept with denom==0, not issue to divider; go IDLE->DONE after edge k+1 with quotient all-ones, remain=numer, res_dz=1.
REQ-023 SHALL hold res_* stable while res_valid=1 and res_ready=0.
REQ-024 SHALL, on res_valid&res_ready, clear res_valid and return to IDLE; requester not accepted in that same cycle (ready earliest next cycle).
REQ-025 SHALL tolerate both requesters' tags in flight simultaneously, in consecutive cycles, without result misrouting.
REQ-026 SHALL ignore req_valid while requester in WAIT or DONE.

Reset
REQ-027 SHALL, on RESET low, asynchronously clear: all FSMs IDLE, tag pipe invalid, RR pointer to requester 0, req_ready/res_valid/res_dz 0, res_quotient/res_remain/div_numer/div_denom 0.
REQ-028 SHALL discard in-flight ops on reset mid-operation; stale divider outputs arriving after reset SHALL not set res_valid.

Structure
REQ-029 SHALL place DIV_W default, FSM state enum and DZ quotient constant (all-ones) in shared package ddsyn_div_pkg.
REQ-030 SHALL implement arbitration in sub-module div_rr_arb (2-way round-robin, pointer register inside).

Verification
REQ-031 SHALL cover: r0 sends 1000/7 alone -> res_valid[0] after edge k+6, quotient 142, remain 6, dz 0.
REQ-032 SHALL cover: both valid same cycle, r0 100/3, r1 50/4 -> r0 accepted first, r1 next cycle; results 33r1 and 12r2 on correct ports, one cycle apart.
REQ-033 SHALL cover: r1 sends 1234/0 -> res_valid[1] after edge k+1, quotient 16'hFFFF, remain 1234, dz 1; divider operands stay 0.
REQ-034 SHALL cover: res_ready[0] held 0 for 10 cycles -> result stable, req_valid[0] ignored; release -> IDLE, new accept next cycle.
REQ-035 SHALL cover: RESET low 2 cycles after r0 accept of 9/2 -> no res_valid after release; next 9/2 gives 4r1.

Source files
------------

// File: rtl/ddsyn_div_pkg.sv
// Shared types and constants for the two-requester divider scheduler.
package ddsyn_div_pkg;

  localparam int DIV_W_DEF = 16;

  // Sliced down to DIV_W at the point of use.
  localparam logic [63:0] DZ_QUOT_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } req_state_e;

  typedef struct packed {
    logic vld;
    logic id;
  } div_tag_t;

endpackage

// File: rtl/div_rr_arb.sv
// Two-way round-robin arbiter; ptr names the requester preferred on a tie.
module div_rr_arb (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr <= 1'b0;
    end else if (|gnt) begin
      ptr <= ~gnt[1];
    end
  end

endmodule

// File: rtl/div_sched.sv
// Schedules two requesters onto one shared pipelined divider and holds
// each requester's result until consumed.
//
// state   | meaning
// ST_IDLE | nothing outstanding, request may be granted
// ST_WAIT | op issued to divider, or divide-by-zero result pending
// ST_DONE | result held on res_* until res_ready
module div_sched
  import ddsyn_div_pkg::*;
#(
  parameter int DIV_LATENCY = 4,
  parameter int DIV_W       = DIV_W_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*DIV_W-1:0] req_numer,
  input  logic [2*DIV_W-1:0] req_denom,
  output logic [1:0]         res_valid,
  input  logic [1:0]         res_ready,
  output logic [2*DIV_W-1:0] res_quotient,
  output logic [2*DIV_W-1:0] res_remain,
  output logic [1:0]         res_dz,
  output logic [DIV_W-1:0]   div_numer,
  output logic [DIV_W-1:0]   div_denom,
  input  logic [DIV_W-1:0]   div_quotient,
  input  logic [DIV_W-1:0]   div_remain
);

  localparam int PIPE_D = DIV_LATENCY + 1;

  req_state_e       state [2];
  logic [1:0]       eligible;
  logic [1:0]       gnt;
  logic [1:0]       dz_pend;
  logic [DIV_W-1:0] dz_numer [2];
  logic             accept;
  logic [DIV_W-1:0] acc_numer;
  logic [DIV_W-1:0] acc_denom;
  logic             issue_vld;
  logic             issue_id;
  div_tag_t         tag_pipe [PIPE_D];
  div_tag_t         tag_out;

  // Gating with RESET keeps req_ready low while reset is asserted.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = RESET && req_valid[i] && (state[i] == ST_IDLE);
    end
  end

  div_rr_arb u_arb (
    .CLK   (CLK),
    .RESET (RESET),
    .req   (eligible),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign acc_numer = gnt[1] ? req_numer[2*DIV_W-1 -: DIV_W] : req_numer[DIV_W-1:0];
  assign acc_denom = gnt[1] ? req_denom[2*DIV_W-1 -: DIV_W] : req_denom[DIV_W-1:0];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_numer <= '0;
      div_denom <= '0;
      issue_vld <= 1'b0;
      issue_id  <= 1'b0;
    end else if (accept && (acc_denom != '0)) begin
      div_numer <= acc_numer;
      div_denom <= acc_denom;
      issue_vld <= 1'b1;
      issue_id  <= gnt[1];
    end else begin
      div_numer <= '0;
      div_denom <= '0;
      issue_vld <= 1'b0;
      issue_id  <= 1'b0;
    end
  end

  // Tag enters on the same edge the divider samples the operands.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int j = 0; j < PIPE_D; j++) begin
        tag_pipe[j] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{vld: issue_vld, id: issue_id};
      for (int j = 1; j < PIPE_D; j++) begin
        tag_pipe[j] <= tag_pipe[j-1];
      end
    end
  end

  assign tag_out = tag_pipe[PIPE_D-1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 2; i++) begin
        state[i]    <= ST_IDLE;
        dz_numer[i] <= '0;
      end
      dz_pend      <= '0;
      res_valid    <= '0;
      res_dz       <= '0;
      res_quotient <= '0;
      res_remain   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (state[i])
          ST_IDLE: begin
            if (gnt[i]) begin
              state[i]    <= ST_WAIT;
              dz_pend[i]  <= (acc_denom == '0);
              dz_numer[i] <= acc_numer;
            end
          end
          ST_WAIT: begin
            if (dz_pend[i]) begin
              state[i]                        <= ST_DONE;
              dz_pend[i]                      <= 1'b0;
              res_valid[i]                    <= 1'b1;
              res_dz[i]                       <= 1'b1;
              res_quotient[i*DIV_W +: DIV_W]  <= DZ_QUOT_ALL[DIV_W-1:0];
              res_remain[i*DIV_W +: DIV_W]    <= dz_numer[i];
            end else if (tag_out.vld && (tag_out.id == 1'(i))) begin
              state[i]                        <= ST_DONE;
              res_valid[i]                    <= 1'b1;
              res_dz[i]                       <= 1'b0;
              res_quotient[i*DIV_W +: DIV_W]  <= div_quotient;
              res_remain[i*DIV_W +: DIV_W]    <= div_remain;
            end
          end
          ST_DONE: begin
            if (res_ready[i]) begin
              state[i]     <= ST_IDLE;
              res_valid[i] <= 1'b0;
            end
          end
          default: state[i] <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural pipelined divider model.
module tb_div_sched;

  localparam int DIV_W = 16;
  localparam int LAT   = 4;

  logic               CLK;
  logic               RESET;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*DIV_W-1:0] req_numer;
  logic [2*DIV_W-1:0] req_denom;
  logic [1:0]         res_valid;
  logic [1:0]         res_ready;
  logic [2*DIV_W-1:0] res_quotient;
  logic [2*DIV_W-1:0] res_remain;
  logic [1:0]         res_dz;
  logic [DIV_W-1:0]   div_numer;
  logic [DIV_W-1:0]   div_denom;
  logic [DIV_W-1:0]   div_quotient;
  logic [DIV_W-1:0]   div_remain;

  logic [DIV_W-1:0]   mq [LAT+1];
  logic [DIV_W-1:0]   mr [LAT+1];

  int n_checks = 0;
  int n_fail   = 0;

  div_sched #(.DIV_LATENCY(LAT), .DIV_W(DIV_W)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_numer    (req_numer),
    .req_denom    (req_denom),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_quotient (res_quotient),
    .res_remain   (res_remain),
    .res_dz       (res_dz),
    .div_numer    (div_numer),
    .div_denom    (div_denom),
    .div_quotient (div_quotient),
    .div_remain   (div_remain)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Divider samples operands on edge e; result visible after edge e+LAT.
  always @(posedge CLK) begin
    mq[0] <= (div_denom != '0) ? div_numer / div_denom : '0;
    mr[0] <= (div_denom != '0) ? div_numer % div_denom : '0;
    for (int j = 1; j <= LAT; j++) begin
      mq[j] <= mq[j-1];
      mr[j] <= mr[j-1];
    end
  end

  assign div_quotient = mq[LAT];
  assign div_remain   = mr[LAT];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] vld, input logic [15:0] n0, input logic [15:0] d0,
                         input logic [15:0] n1, input logic [15:0] d1);
    req_valid = vld;
    req_numer = {n1, n0};
    req_denom = {d1, d0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET     = 1'b1;
    req_valid = '0;
    req_numer = '0;
    req_denom = '0;
    res_ready = '0;
    #1 RESET = 1'b0;
    #1;
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_res_dz", 32'(res_dz), 32'd0);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_res_quotient", res_quotient, 32'd0);
    check_val("rst_res_remain", res_remain, 32'd0);
    check_val("rst_div_numer", 32'(div_numer), 32'd0);
    check_val("rst_div_denom", 32'(div_denom), 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // both requesters at once: r0 100/3, r1 50/4
    set_req(2'b11, 16'd100, 16'd3, 16'd50, 16'd4);
    #1 check_val("rr_first_grant", 32'(req_ready), 32'd1);
    @(negedge CLK);
    check_val("rr_second_grant", 32'(req_ready), 32'd2);
    check_val("rr_div_numer0", 32'(div_numer), 32'd100);
    check_val("rr_div_denom0", 32'(div_denom), 32'd3);
    @(negedge CLK);
    req_valid = '0;
    #1;
    check_val("rr_div_numer1", 32'(div_numer), 32'd50);
    check_val("rr_div_denom1", 32'(div_denom), 32'd4);
    check_val("rr_no_grant", 32'(req_ready), 32'd0);
    repeat (4) @(negedge CLK);
    check_val("rr_early_valid", 32'(res_valid), 32'd0);
    check_val("rr_div_idle", 32'(div_numer), 32'd0);
    @(negedge CLK);
    check_val("rr_valid_r0", 32'(res_valid), 32'd1);
    check_val("rr_q0", 32'(res_quotient[15:0]), 32'd33);
    check_val("rr_rem0", 32'(res_remain[15:0]), 32'd1);
    check_val("rr_dz0", 32'(res_dz), 32'd0);
    @(negedge CLK);
    check_val("rr_valid_both", 32'(res_valid), 32'd3);
    check_val("rr_q1", 32'(res_quotient[31:16]), 32'd12);
    check_val("rr_rem1", 32'(res_remain[31:16]), 32'd2);
    check_val("rr_q0_held", 32'(res_quotient[15:0]), 32'd33);
    res_ready = 2'b11;
    @(negedge CLK);
    res_ready = '0;
    check_val("rr_released", 32'(res_valid), 32'd0);

    // r0 alone: 1000/7
    set_req(2'b01, 16'd1000, 16'd7, 16'd0, 16'd0);
    #1 check_val("solo_grant", 32'(req_ready), 32'd1);
    @(negedge CLK);
    req_valid = '0;
    check_val("solo_div_numer", 32'(div_numer), 32'd1000);
    check_val("solo_div_denom", 32'(div_denom), 32'd7);
    repeat (5) @(negedge CLK);
    check_val("solo_early_valid", 32'(res_valid), 32'd0);
    @(negedge CLK);
    check_val("solo_valid", 32'(res_valid), 32'd1);
    check_val("solo_q", 32'(res_quotient[15:0]), 32'd142);
    check_val("solo_rem", 32'(res_remain[15:0]), 32'd6);
    check_val("solo_dz", 32'(res_dz), 32'd0);
    res_ready = 2'b01;
    @(negedge CLK);
    res_ready = '0;
    check_val("solo_released", 32'(res_valid), 32'd0);

    // r1 divide by zero: 1234/0
    set_req(2'b10, 16'd0, 16'd0, 16'd1234, 16'd0);
    #1 check_val("dz_grant", 32'(req_ready), 32'd2);
    @(negedge CLK);
    req_valid = '0;
    check_val("dz_not_yet", 32'(res_valid), 32'd0);
    check_val("dz_div_numer0", 32'(div_numer), 32'd0);
    check_val("dz_div_denom0", 32'(div_denom), 32'd0);
    @(negedge CLK);
    check_val("dz_valid", 32'(res_valid), 32'd2);
    check_val("dz_q", 32'(res_quotient[31:16]), 32'hFFFF);
    check_val("dz_rem", 32'(res_remain[31:16]), 32'd1234);
    check_val("dz_flag", 32'(res_dz), 32'd2);
    check_val("dz_div_numer1", 32'(div_numer), 32'd0);
    res_ready = 2'b10;
    @(negedge CLK);
    res_ready = '0;
    check_val("dz_released", 32'(res_valid), 32'd0);

    // r0 result held under back-pressure, new request ignored meanwhile
    set_req(2'b01, 16'd50, 16'd5, 16'd0, 16'd0);
    #1 check_val("hold_grant", 32'(req_ready), 32'd1);
    @(negedge CLK);
    req_valid = '0;
    repeat (6) @(negedge CLK);
    check_val("hold_valid", 32'(res_valid), 32'd1);
    check_val("hold_q_first", 32'(res_quotient[15:0]), 32'd10);
    set_req(2'b01, 16'd77, 16'd7, 16'd0, 16'd0);
    for (int c = 0; c < 10; c++) begin
      #1;
      check_val("hold_ignored", 32'(req_ready), 32'd0);
      check_val("hold_q", 32'(res_quotient[15:0]), 32'd10);
      check_val("hold_rem", 32'(res_remain[15:0]), 32'd0);
      check_val("hold_div_idle", 32'(div_numer), 32'd0);
      @(negedge CLK);
    end
    check_val("hold_still_valid", 32'(res_valid), 32'd1);
    res_ready = 2'b01;
    #1 check_val("hold_no_same_cycle", 32'(req_ready), 32'd0);
    @(negedge CLK);
    res_ready = '0;
    check_val("hold_released", 32'(res_valid), 32'd0);
    check_val("hold_regrant", 32'(req_ready), 32'd1);
    @(negedge CLK);
    req_valid = '0;
    check_val("hold_div_numer", 32'(div_numer), 32'd77);
    repeat (6) @(negedge CLK);
    check_val("hold2_valid", 32'(res_valid), 32'd1);
    check_val("hold2_q", 32'(res_quotient[15:0]), 32'd11);
    check_val("hold2_rem", 32'(res_remain[15:0]), 32'd0);
    res_ready = 2'b01;
    @(negedge CLK);
    res_ready = '0;

    // reset two cycles into a 9/2 operation
    set_req(2'b01, 16'd9, 16'd2, 16'd0, 16'd0);
    #1 check_val("rstop_grant", 32'(req_ready), 32'd1);
    @(negedge CLK);
    req_valid = '0;
    check_val("rstop_div_numer", 32'(div_numer), 32'd9);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    req_valid = 2'b01;
    #1;
    check_val("rstop_ready_in_reset", 32'(req_ready), 32'd0);
    check_val("rstop_valid_in_reset", 32'(res_valid), 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1 check_val("rstop_regrant", 32'(req_ready), 32'd1);
    @(negedge CLK);
    req_valid = '0;
    check_val("rstop_div_numer2", 32'(div_numer), 32'd9);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check_val("rstop_no_stale", 32'(res_valid), 32'd0);
    end
    @(negedge CLK);
    check_val("rstop_valid", 32'(res_valid), 32'd1);
    check_val("rstop_q", 32'(res_quotient[15:0]), 32'd4);
    check_val("rstop_rem", 32'(res_remain[15:0]), 32'd1);
    res_ready = 2'b01;
    @(negedge CLK);
    res_ready = '0;
    check_val("rstop_released", 32'(res_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
